seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display scanner. It is the next generation of the fixed 6-digit NCO counter display path. An internal NCO sets the digit scan rate at run time. Features: per-digit hex glyph decode, decimal points, per-digit blanking, leading-zero suppression, frame-coherent input snapshot, and a dead-time gap between digits to suppress ghosting. Sits between the datapath (counter/clock values) and the board display pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_nco.sv | 30 +++
 rtl/seg_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and glyph decode for the multiplexed 7-segment scanner.
// Glyph bit order is {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Full hex decode: 0-9 plus A, b, C, d, E, F.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        hex2seg = HEX_GLYPH[nib];
    endfunction

endpackage

// File: rtl/seg_nco.sv
// seg_nco: phase accumulator whose carry-out serves as a rate tick.
// The tick is combinational from the current accumulator and increment, so a
// consumer sees it in the cycle the wrap happens.
module seg_nco #(
    parameter int NCO_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCO_W-1:0] i_nco_num,
    output logic             o_tick
);

    logic [NCO_W-1:0] acc_q;
    logic [NCO_W-1:0] acc_d;
    logic [NCO_W:0]   sum_s;

    assign sum_s  = {1'b0, acc_q} + {1'b0, i_nco_num};
    assign acc_d  = sum_s[NCO_W-1:0];
    assign o_tick = sum_s[NCO_W];

    // Accumulator register, wraps modulo 2^NCO_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {NCO_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with NCO-paced digit rate,
// dead-time between digits, frame-coherent input snapshot, per-digit blanking
// and leading-zero suppression.
// Optional build macro SEG_DIM_EN adds i_dim and PWM gating of the enables.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG      = 6,
    parameter int NCO_W     = 32,
    parameter int BLANK_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCO_W-1:0]        i_nco_num,
    input  logic [4*NDIG-1:0]       i_bcd,
    input  logic [NDIG-1:0]         i_dp,
    input  logic [NDIG-1:0]         i_blank,
    input  logic                    i_lzs,
`ifdef SEG_DIM_EN
    input  logic [3:0]              i_dim,
`endif
    output logic [NDIG-1:0]         o_seg_enb,
    output logic                    o_seg_dp,
    output logic [6:0]              o_seg,
    output logic [$clog2(NDIG)-1:0] o_digit_idx,
    output logic                    o_frame
);

    localparam int IDX_W = $clog2(NDIG);
    localparam int CNT_W = $clog2(BLANK_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYC - 1);

    logic                tick_s;
    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [NDIG-1:0]     dp_q, dp_d;
    logic [NDIG-1:0]     blank_q, blank_d;
    logic                lzs_q, lzs_d;
    logic [NDIG-1:0]     enb_q, enb_d;
    logic [6:0]          seg_q, seg_d;
    logic                sdp_q, sdp_d;
    logic                frame_q, frame_d;
    logic                wrap_s;
    logic                gate_s;
    logic                run_s;
    logic [NDIG-1:0]     supp_s;
    logic [3:0]          nib_s;

    seg_nco #(.NCO_W(NCO_W)) u_nco (
        .clk       (clk),
        .rst       (rst),
        .i_nco_num (i_nco_num),
        .o_tick    (tick_s)
    );

`ifdef SEG_DIM_EN
    logic [3:0] pwm_q;

    // Free-running brightness PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
        end
    end

    assign gate_s = (pwm_q <= i_dim);
`else
    assign gate_s = 1'b1;
`endif

    // Scan FSM next state; the snapshot is taken on the edge that wraps to digit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_s  = 1'b0;
        case (state_q)
            SHOW: begin
                cnt_d = {CNT_W{1'b0}};
                if (tick_s) begin
                    state_d = BLANK;
                end else begin
                    state_d = SHOW;
                end
            end
            BLANK: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SHOW;
                    cnt_d   = {CNT_W{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        idx_d  = {IDX_W{1'b0}};
                        wrap_s = 1'b1;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Frame snapshot select: fresh inputs at the wrap edge, otherwise hold.
    always_comb begin
        if (wrap_s) begin
            bcd_d   = i_bcd;
            dp_d    = i_dp;
            blank_d = i_blank;
            lzs_d   = i_lzs;
        end else begin
            bcd_d   = bcd_q;
            dp_d    = dp_q;
            blank_d = blank_q;
            lzs_d   = lzs_q;
        end
    end

    // Leading-zero run from the top digit down; digit 0 always shows.
    always_comb begin
        supp_s = {NDIG{1'b0}};
        run_s  = lzs_d;
        for (int k = NDIG - 1; k >= 1; k--) begin
            run_s     = run_s & (bcd_d[k*4 +: 4] == 4'd0);
            supp_s[k] = run_s;
        end
    end

    // Output next values, computed from the next state so glyph and enable align.
    always_comb begin
        nib_s   = bcd_d[idx_d*4 +: 4];
        frame_d = wrap_s;
        if (state_d == SHOW) begin
            enb_d = gate_s ? ({{(NDIG-1){1'b0}}, 1'b1} << idx_d) : {NDIG{1'b0}};
            sdp_d = dp_d[idx_d];
            if (blank_d[idx_d] | supp_s[idx_d]) begin
                seg_d = 7'h00;
            end else begin
                seg_d = hex2seg(nib_s);
            end
        end else begin
            enb_d = {NDIG{1'b0}};
            sdp_d = 1'b0;
            seg_d = 7'h00;
        end
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= IDX_LAST;
            bcd_q   <= {(4*NDIG){1'b0}};
            dp_q    <= {NDIG{1'b0}};
            blank_q <= {NDIG{1'b0}};
            lzs_q   <= 1'b0;
            enb_q   <= {NDIG{1'b0}};
            seg_q   <= 7'h00;
            sdp_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            lzs_q   <= lzs_d;
            enb_q   <= enb_d;
            seg_q   <= seg_d;
            sdp_q   <= sdp_d;
            frame_q <= frame_d;
        end
    end

    assign o_seg_enb   = enb_q;
    assign o_seg       = seg_q;
    assign o_seg_dp    = sdp_q;
    assign o_frame     = frame_q;
    assign o_digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scenarios plus randomized stimulus, checked every
// cycle against a timeline model of the scanner (lit/dark periods, digit order,
// frame snapshots, glyph table and zero suppression).
module tb_seg_scan_ctrl;

    localparam int NDIG      = 6;
    localparam int NCO_W     = 32;
    localparam int BLANK_CYC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCO_W-1:0]  nco;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   blank;
    logic              lzs;
    logic [3:0]        dim;
    logic [NDIG-1:0]   seg_enb;
    logic              seg_dp;
    logic [6:0]        seg;
    logic [2:0]        digit_idx;
    logic              frame;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NDIG(NDIG), .NCO_W(NCO_W), .BLANK_CYC(BLANK_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_nco_num   (nco),
        .i_bcd       (bcd),
        .i_dp        (dp),
        .i_blank     (blank),
        .i_lzs       (lzs),
`ifdef SEG_DIM_EN
        .i_dim       (dim),
`endif
        .o_seg_enb   (seg_enb),
        .o_seg_dp    (seg_dp),
        .o_seg       (seg),
        .o_digit_idx (digit_idx),
        .o_frame     (frame)
    );

    logic [6:0] glyph_ref [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    int checks   = 0;
    int failures = 0;

    // model state
    longint          m_acc;
    bit              m_lit;
    int              m_dark;
    int              m_dig;
    int              m_pwm;
    logic [23:0]     m_bcd;
    logic [5:0]      m_dp;
    logic [5:0]      m_blank;
    bit              m_lzs;
    logic [5:0]      e_enb;
    logic [6:0]      e_seg;
    logic            e_dp;
    logic [2:0]      e_idx;
    logic            e_frame;

    int  cyc = 0;
    int  frames_seen = 0;
    int  last_frame = -1;
    bit  chk_period = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the reference timeline by one clock edge.
    task automatic model_step();
        longint sum;
        bit     tick;
        bit     gate;
        bit     supp;
        int     hi;
        gate = 1'b1;
        if (rst) begin
            m_acc = 0; m_lit = 1'b0; m_dark = BLANK_CYC; m_dig = NDIG - 1;
            m_bcd = '0; m_dp = '0; m_blank = '0; m_lzs = 1'b0; m_pwm = 0;
            e_frame = 1'b0;
        end else begin
            sum   = m_acc + longint'({32'h0, nco});
            tick  = (sum >> 32) != 0;
            m_acc = sum & 64'h0000_0000_FFFF_FFFF;
            e_frame = 1'b0;
            if (m_lit) begin
                if (tick) begin
                    m_lit  = 1'b0;
                    m_dark = BLANK_CYC;
                end
            end else begin
                m_dark--;
                if (m_dark == 0) begin
                    m_dig = (m_dig + 1) % NDIG;
                    m_lit = 1'b1;
                    if (m_dig == 0) begin
                        e_frame = 1'b1;
                        m_bcd = bcd; m_dp = dp; m_blank = blank; m_lzs = lzs;
                    end
                end
            end
`ifdef SEG_DIM_EN
            gate  = (m_pwm <= int'(dim));
            m_pwm = (m_pwm + 1) % 16;
`endif
        end
        // highest digit holding a nonzero value (-1 if all zero)
        hi = -1;
        for (int k = 0; k < NDIG; k++) begin
            if (m_bcd[k*4 +: 4] != 4'd0) hi = k;
        end
        supp  = m_lzs && (m_dig != 0) && (m_dig > hi);
        e_idx = 3'(m_dig);
        if (m_lit) begin
            e_enb = gate ? 6'(1 << m_dig) : 6'h0;
            e_seg = (m_blank[m_dig] || supp) ? 7'h00 : glyph_ref[m_bcd[m_dig*4 +: 4]];
            e_dp  = m_dp[m_dig];
        end else begin
            e_enb = 6'h0;
            e_seg = 7'h00;
            e_dp  = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_eq("enb",   32'(seg_enb),   32'(e_enb));
        check_eq("seg",   32'(seg),       32'(e_seg));
        check_eq("dp",    32'(seg_dp),    32'(e_dp));
        check_eq("idx",   32'(digit_idx), 32'(e_idx));
        check_eq("frame", 32'(frame),     32'(e_frame));
        if (frame === 1'b1) begin
            frames_seen++;
            if (chk_period && last_frame >= 0) begin
                check_eq("frame_period", 32'(cyc - last_frame), 32'd48);
            end
            last_frame = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; nco = '0; bcd = '0; dp = '0; blank = '0; lzs = 1'b0; dim = 4'd15;

        // reset and idle with no ticks: digit 0 stays lit, one frame pulse
        do_reset(3);
        check_eq("rst_idx", 32'(digit_idx), 32'd5);
        frames_seen = 0;
        run(40);
        check_eq("idle_frames", 32'(frames_seen), 32'd1);
        check_eq("idle_enb", 32'(seg_enb), 32'd1);

        // scan order and 48-cycle frame period
        nco = 32'h4000_0000; bcd = 24'h123456; dp = 6'b000101;
        do_reset(1);
        last_frame = -1; chk_period = 1'b1; frames_seen = 0;
        run(200);
        chk_period = 1'b0;
        check_eq("scan_frames", 32'(frames_seen), 32'd5);

        // leading-zero suppression on and off
        bcd = 24'h000070; lzs = 1'b1; blank = 6'b010000;
        run(100);
        lzs = 1'b0; blank = '0;
        run(100);

        // coherence: change inputs while digit 3 is lit
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            cycle();
            if (seg_enb == 6'b001000) found = 1'b1;
        end
        check_eq("wait_d3", 32'(found), 32'd1);
        bcd = 24'hABCDEF; dp = 6'b100000;
        run(100);

        // mid-scan reset while digit 2 is lit
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            cycle();
            if (seg_enb == 6'b000100) found = 1'b1;
        end
        check_eq("wait_d2", 32'(found), 32'd1);
        rst = 1'b1;
        cycle();
        check_eq("midrst_enb", 32'(seg_enb), 32'd0);
        check_eq("midrst_idx", 32'(digit_idx), 32'd5);
        rst = 1'b0; nco = '0;
        run(20);

`ifdef SEG_DIM_EN
        // dimming with a constant lit digit
        dim = 4'd3;
        run(64);
        dim = 4'd15;
        run(32);
`endif

        // randomized stimulus
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) begin
                bcd = 24'($urandom());
                if ($urandom_range(0, 1) == 1) bcd = bcd >> (4 * $urandom_range(0, 6));
                dp    = 6'($urandom());
                blank = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'h0;
                lzs   = 1'($urandom());
                dim   = 4'($urandom());
            end
            if ($urandom_range(0, 149) == 0 || c == 0) begin
                case ($urandom_range(0, 4))
                    0:       nco = 32'h0000_0000;
                    1:       nco = 32'h4000_0000;
                    2:       nco = 32'h8000_0000;
                    3:       nco = 32'hFFFF_FFFF;
                    default: nco = $urandom();
                endcase
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
